// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: default widths,
// the queued writeback entry and the starvation-stall state encoding.
package mips_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              kill;
    } wb_entry_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry queue of secondary writebacks with kill-by-register-match.
// With WB_BYPASS_EN the live entries are exported oldest-first for forwarding search.
module wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    kill_en,
    input  logic [ADDR_W-1:0]       kill_reg,
`ifdef WB_BYPASS_EN
    output wb_entry_t [DEPTH-1:0]   ents,
    output logic [DEPTH-1:0]        live,
`endif
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_r;
    logic [PW:0]           wr_ptr_r;
    logic [PW:0]           rd_ptr_r;
    logic [PW:0]           count_s;
    logic [DEPTH-1:0]      slot_live_s;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[PW-1:0]];

    // A physical slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_live_s[i] = {1'b0, PW'(PW'(i) - rd_ptr_r[PW-1:0])} < count_s;
        end
    end

`ifdef WB_BYPASS_EN
    // Age-ordered view: index 0 is the head, higher indices are younger.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ents[k] = mem_r[PW'(rd_ptr_r[PW-1:0] + PW'(k))];
            live[k] = (PW+1)'(k) < count_s;
        end
    end
`endif

    // Storage, pointers and kill marking; the push slot is never live, so it cannot collide with a kill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && slot_live_s[i] && (mem_r[i].rd == kill_reg)) begin
                    mem_r[i].kill <= 1'b1;
                end
            end
            if (do_push_s) begin
                mem_r[wr_ptr_r[PW-1:0]] <= push_entry;
                wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges primary (WB stage) and queued secondary writebacks onto one
// register-file write port, with a starvation stall. Optional forwarding via WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W       = mips_wb_pkg::DATA_W,
    parameter int ADDR_W       = mips_wb_pkg::ADDR_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_reg,
    input  logic [DATA_W-1:0] p_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_reg,
    input  logic [DATA_W-1:0] s_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] fwd_reg_a,
    input  logic [ADDR_W-1:0] fwd_reg_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
`endif
    output logic              stall
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    mips_wb_pkg::wb_entry_t    push_entry_s;
    mips_wb_pkg::wb_entry_t    head_s;
    mips_wb_pkg::stall_state_t state_r;
    mips_wb_pkg::stall_state_t state_next_s;
    logic              full_s;
    logic              empty_s;
    logic              p_req_s;
    logic              s_push_s;
    logic              pop_s;
    logic [CW-1:0]     starve_cnt_r;
    logic              reg_write_r;
    logic [ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0] write_data_r;

    // Register 0 is hardwired; such requests are dropped (secondary still handshakes).
    assign p_req_s      = p_valid && (p_reg != '0);
    assign s_ready      = !full_s;
    assign s_push_s     = s_valid && !full_s && (s_reg != '0);
    assign pop_s        = !p_req_s && !empty_s;
    assign push_entry_s = '{rd: s_reg, data: s_data, kill: 1'b0};

`ifdef WB_BYPASS_EN
    mips_wb_pkg::wb_entry_t [DEPTH-1:0] ents_s;
    logic [DEPTH-1:0]                   live_s;
`endif

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (s_push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .kill_en    (p_req_s),
        .kill_reg   (p_reg),
`ifdef WB_BYPASS_EN
        .ents       (ents_s),
        .live       (live_s),
`endif
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Write-port stage: primary wins, else the FIFO head drains (a killed head issues no write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= '0;
            write_data_r <= '0;
        end else if (p_req_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= p_reg;
            write_data_r <= p_data;
        end else if (pop_s) begin
            reg_write_r  <= !head_s.kill;
            write_reg_r  <= head_s.rd;
            write_data_r <= head_s.data;
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    assign reg_write  = reg_write_r;
    assign write_reg  = write_reg_r;
    assign write_data = write_data_r;

    // Starvation counter: cycles the head has waited, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= '0;
        end else if (empty_s || pop_s) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != CW'(STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + CW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Stall state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= mips_wb_pkg::ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stall next-state: enter after a full wait, leave on the first pop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            mips_wb_pkg::ST_RUN: begin
                if ((starve_cnt_r == CW'(STARVE_LIMIT)) && !pop_s) begin
                    state_next_s = mips_wb_pkg::ST_STALL;
                end else begin
                    state_next_s = mips_wb_pkg::ST_RUN;
                end
            end
            mips_wb_pkg::ST_STALL: begin
                if (pop_s) begin
                    state_next_s = mips_wb_pkg::ST_RUN;
                end else begin
                    state_next_s = mips_wb_pkg::ST_STALL;
                end
            end
            default: state_next_s = mips_wb_pkg::ST_RUN;
        endcase
    end

    // Stall output decoded from the state register.
    always_comb begin
        stall = 1'b0;
        case (state_r)
            mips_wb_pkg::ST_STALL: stall = 1'b1;
            default:               stall = 1'b0;
        endcase
    end

`ifdef WB_BYPASS_EN
    // Youngest pending write wins: output stage is oldest, then FIFO head to tail.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] idx);
        logic [DATA_W:0] res;
        res = '0;
        if (idx != '0) begin
            if (reg_write_r && (write_reg_r == idx)) begin
                res = {1'b1, write_data_r};
            end else begin
                res = '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (live_s[k] && !ents_s[k].kill && (ents_s[k].rd == idx)) begin
                    res = {1'b1, ents_s[k].data};
                end else begin
                    res = res;
                end
            end
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Combinational forwarding lookups.
    always_comb begin
        {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_reg_a);
        {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_reg_b);
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic,
// compared against a queue-based model of the writeback rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        p_valid;
    logic [4:0]  p_reg;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_reg;
    logic [31:0] s_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        stall;
`ifdef WB_BYPASS_EN
    logic [4:0]  fwd_reg_a;
    logic [4:0]  fwd_reg_b;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_a;
    logic [31:0] fwd_data_b;
`endif

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_valid    (p_valid),
        .p_reg      (p_reg),
        .p_data     (p_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_reg      (s_reg),
        .s_data     (s_data),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
`ifdef WB_BYPASS_EN
        .fwd_reg_a  (fwd_reg_a),
        .fwd_reg_b  (fwd_reg_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
`endif
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } m_ent_t;

    m_ent_t      q[$];
    logic        m_rw;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_stall;
    int          m_waits;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] m_fwd(input logic [4:0] idx);
        logic [32:0] r;
        r = '0;
        if (idx != 5'd0) begin
            if (m_rw && m_reg == idx) r = {1'b1, m_data};
            foreach (q[i]) if (!q[i].kill && q[i].rd == idx) r = {1'b1, q[i].data};
        end
        return r;
    endfunction

    // Called at a negedge: check current outputs, drive one cycle of inputs, advance the model.
    task automatic step(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sr, input logic [31:0] sd);
        bit     popped;
        bit     was_nonempty;
        m_ent_t e;
        chk("reg_write", {63'd0, reg_write}, {63'd0, m_rw});
        if (m_rw) begin
            chk("write_reg", {59'd0, write_reg}, {59'd0, m_reg});
            chk("write_data", {32'd0, write_data}, {32'd0, m_data});
        end
        chk("stall", {63'd0, stall}, {63'd0, m_stall});
        chk("s_ready", {63'd0, s_ready}, {63'd0, (q.size() < DEPTH)});
        p_valid = pv; p_reg = pr; p_data = pd;
        s_valid = sv; s_reg = sr; s_data = sd;
`ifdef WB_BYPASS_EN
        fwd_reg_a = 5'($urandom_range(0, 7));
        fwd_reg_b = 5'($urandom_range(0, 7));
        #1;
        chk("fwd_a", {31'd0, fwd_hit_a, fwd_data_a}, {31'd0, m_fwd(fwd_reg_a)});
        chk("fwd_b", {31'd0, fwd_hit_b, fwd_data_b}, {31'd0, m_fwd(fwd_reg_b)});
`endif
        popped       = 1'b0;
        was_nonempty = (q.size() != 0);
        begin
            bit full_now;
            full_now = (q.size() == DEPTH);
            if (pv && pr != 5'd0) begin
                foreach (q[i]) if (q[i].rd == pr) q[i].kill = 1'b1;
                m_rw = 1'b1; m_reg = pr; m_data = pd;
            end else if (q.size() != 0) begin
                e = q.pop_front();
                popped = 1'b1;
                m_rw = !e.kill; m_reg = e.rd; m_data = e.data;
            end else begin
                m_rw = 1'b0;
            end
            if (sv && !full_now && sr != 5'd0) q.push_back('{rd: sr, data: sd, kill: 1'b0});
        end
        m_stall = m_stall ? !popped : ((m_waits == LIMIT) && !popped);
        m_waits = (!was_nonempty || popped) ? 0 : ((m_waits < LIMIT) ? m_waits + 1 : LIMIT);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asserted at a negedge, mid-cycle; everything queued must be discarded.
    task automatic apply_reset();
        reset = 1'b1;
        p_valid = 1'b0; p_reg = 5'd0; p_data = 32'd0;
        s_valid = 1'b0; s_reg = 5'd0; s_data = 32'd0;
`ifdef WB_BYPASS_EN
        fwd_reg_a = 5'd3; fwd_reg_b = 5'd7;
`endif
        q.delete();
        m_rw = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_stall = 1'b0; m_waits = 0;
        #1;
        chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
        chk("rst_write_reg", {59'd0, write_reg}, 64'd0);
        chk("rst_write_data", {32'd0, write_data}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
`ifdef WB_BYPASS_EN
        chk("rst_fwd_hit", {62'd0, fwd_hit_a, fwd_hit_b}, 64'd0);
        chk("rst_fwd_data", {fwd_data_a, fwd_data_b}, 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        @(negedge clk);
        apply_reset();

        // Primary only.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Secondary drain: written two cycles after the push.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        idle(3);

        // Starvation: head waits behind continuous primary traffic.
        step(1'b1, 5'd4, 32'h1, 1'b1, 5'd3, 32'hAA);
        for (int i = 0; i < 12; i++) step(1'b1, 5'd4, 32'(i), 1'b0, 5'd0, 32'd0);
        idle(3);

        // Kill: the newer primary value for reg 9 survives.
        step(1'b1, 5'd10, 32'h5, 1'b1, 5'd9, 32'h1);
        step(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Fill the FIFO, attempt an overflow push, then a handshake to reg 0.
        for (int i = 0; i < 5; i++) step(1'b1, 5'd1, 32'(i), 1'b1, 5'(11 + i), 32'(100 + i));
        idle(6);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        idle(2);

        // Reset mid-drain with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd2, 32'(i), 1'b1, 5'(3 + i), 32'(200 + i));
        idle(1);
        apply_reset();
        idle(4);

        // Random traffic with varying primary pressure.
        for (int ph = 0; ph < 8; ph++) begin
            int pv_pct;
            pv_pct = (ph % 4) * 30;
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(0, 99) < pv_pct),
                     5'($urandom_range(0, 7)), $urandom(),
                     ($urandom_range(0, 1) == 1),
                     5'($urandom_range(0, 7)), $urandom());
            end
        end
        idle(LIMIT + DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
